// File: rtl/pipe_stage_reg_if.sv
// Bus bundle for pipe_stage_reg: stage control, upstream slot fields and registered outputs.
// master drives the upstream side; slave is the register stage itself.
interface pipe_stage_reg_if #(
  parameter int INSTR_W = 32,
  parameter int PC_W    = 32,
  parameter int DATA_W  = 96,
  parameter int WA_W    = 5,
  parameter int TNEW_W  = 2
) ();
  logic               en;
  logic               flush;
  logic               in_valid;
  logic [INSTR_W-1:0] in_instr;
  logic [PC_W-1:0]    in_pc;
  logic [DATA_W-1:0]  in_data;
  logic [WA_W-1:0]    in_wa;
  logic [TNEW_W-1:0]  in_tnew;
  logic               out_valid;
  logic [INSTR_W-1:0] out_instr;
  logic [PC_W-1:0]    out_pc;
  logic [DATA_W-1:0]  out_data;
  logic [WA_W-1:0]    out_wa;
  logic [TNEW_W-1:0]  out_tnew;
  logic               out_fwd_ready;

  modport master (
    output en, flush, in_valid, in_instr, in_pc, in_data, in_wa, in_tnew,
    input  out_valid, out_instr, out_pc, out_data, out_wa, out_tnew, out_fwd_ready
  );

  modport slave (
    input  en, flush, in_valid, in_instr, in_pc, in_data, in_wa, in_tnew,
    output out_valid, out_instr, out_pc, out_data, out_wa, out_tnew, out_fwd_ready
  );
endinterface

// File: rtl/pipe_stage_reg.sv
// Generic MIPS inter-stage register with hold, flush bubble, saturating Tnew countdown and fwd-ready flag.
// Optional macro PIPE_STAT_EN adds free-running bubble/hold event counters.
module pipe_stage_reg #(
  parameter int              INSTR_W       = 32,
  parameter int              PC_W          = 32,
  parameter int              DATA_W        = 96,
  parameter int              WA_W          = 5,
  parameter int              TNEW_W        = 2,
  parameter logic [PC_W-1:0] PC_RESET      = 32'h0000_3000,
  parameter bit              FLUSH_KEEP_PC = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  pipe_stage_reg_if.slave    bus
`ifdef PIPE_STAT_EN
  ,
  output logic [31:0]        stat_bubble_cnt,
  output logic [31:0]        stat_hold_cnt
`endif
);

  function automatic logic [TNEW_W-1:0] tnew_dec(input logic [TNEW_W-1:0] t);
    return (t == '0) ? '0 : t - TNEW_W'(1);
  endfunction

  logic               valid_p1;
  logic [INSTR_W-1:0] instr_p1;
  logic [PC_W-1:0]    pc_p1;
  logic [DATA_W-1:0]  data_p1;
  logic [WA_W-1:0]    wa_p1;
  logic [TNEW_W-1:0]  tnew_p1;

  // ---- p0 -> p1 : reset > flush > hold > load
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_p1 <= 1'b0;
      instr_p1 <= '0;
      pc_p1    <= PC_RESET;
      data_p1  <= '0;
      wa_p1    <= '0;
      tnew_p1  <= '0;
    end else if (bus.flush) begin
      valid_p1 <= 1'b0;
      instr_p1 <= '0;
      pc_p1    <= FLUSH_KEEP_PC ? bus.in_pc : PC_RESET;
      data_p1  <= '0;
      wa_p1    <= '0;
      tnew_p1  <= '0;
    end else if (bus.en) begin
      valid_p1 <= bus.in_valid;
      instr_p1 <= bus.in_instr;
      pc_p1    <= bus.in_pc;
      data_p1  <= bus.in_data;
      // An empty slot must never advertise a forwardable result.
      wa_p1    <= bus.in_valid ? bus.in_wa : '0;
      tnew_p1  <= bus.in_valid ? tnew_dec(bus.in_tnew) : '0;
    end
  end

  assign bus.out_valid     = valid_p1;
  assign bus.out_instr     = instr_p1;
  assign bus.out_pc        = pc_p1;
  assign bus.out_data      = data_p1;
  assign bus.out_wa        = wa_p1;
  assign bus.out_tnew      = tnew_p1;
  assign bus.out_fwd_ready = valid_p1 & (tnew_p1 == '0) & (wa_p1 != '0);

`ifdef PIPE_STAT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_bubble_cnt <= '0;
      stat_hold_cnt   <= '0;
    end else if (bus.flush) begin
      stat_bubble_cnt <= stat_bubble_cnt + 32'd1;
    end else if (!bus.en) begin
      stat_hold_cnt   <= stat_hold_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed self-checking bench for pipe_stage_reg (default parameters, optional PIPE_STAT_EN).
module tb_pipe_stage_reg;
  localparam int          INSTR_W = 32, PC_W = 32, DATA_W = 96, WA_W = 5, TNEW_W = 2;
  localparam bit          KEEP_PC = 1'b1;
  localparam logic [31:0] PC_RST  = 32'h0000_3000;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  pipe_stage_reg_if #(.INSTR_W(INSTR_W), .PC_W(PC_W), .DATA_W(DATA_W), .WA_W(WA_W), .TNEW_W(TNEW_W)) bus ();

`ifdef PIPE_STAT_EN
  logic [31:0] stat_bubble_cnt, stat_hold_cnt;
`endif

  pipe_stage_reg #(
    .INSTR_W(INSTR_W), .PC_W(PC_W), .DATA_W(DATA_W), .WA_W(WA_W), .TNEW_W(TNEW_W),
    .PC_RESET(PC_RST), .FLUSH_KEEP_PC(KEEP_PC)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
`ifdef PIPE_STAT_EN
    ,
    .stat_bubble_cnt(stat_bubble_cnt),
    .stat_hold_cnt(stat_hold_cnt)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic en, input logic fl, input logic v, input logic [31:0] instr,
                       input logic [31:0] pc, input logic [95:0] data, input logic [4:0] wa,
                       input logic [1:0] tnew);
    bus.en = en; bus.flush = fl; bus.in_valid = v; bus.in_instr = instr;
    bus.in_pc = pc; bus.in_data = data; bus.in_wa = wa; bus.in_tnew = tnew;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF, 32'h0000_ABCD, {3{32'hA5A5_5A5A}}, 5'd17, 2'd3);
    step();
    step();
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", bus.out_valid); end
    total++; if (bus.out_instr !== 32'h0) begin bad++; $display("FAIL rst_instr got=%h want=0", bus.out_instr); end
    total++; if (bus.out_pc !== 32'h3000) begin bad++; $display("FAIL rst_pc got=%h want=3000", bus.out_pc); end
    total++; if (bus.out_data !== 96'h0) begin bad++; $display("FAIL rst_data got=%h want=0", bus.out_data); end
    total++; if (bus.out_wa !== 5'd0) begin bad++; $display("FAIL rst_wa got=%0d want=0", bus.out_wa); end
    total++; if (bus.out_tnew !== 2'd0) begin bad++; $display("FAIL rst_tnew got=%0d want=0", bus.out_tnew); end
    total++; if (bus.out_fwd_ready !== 1'b0) begin bad++; $display("FAIL rst_fwd got=%b want=0", bus.out_fwd_ready); end
`ifdef PIPE_STAT_EN
    total++; if (stat_hold_cnt !== 32'd0) begin bad++; $display("FAIL rst_holdcnt got=%0d want=0", stat_hold_cnt); end
    total++; if (stat_bubble_cnt !== 32'd0) begin bad++; $display("FAIL rst_bubcnt got=%0d want=0", stat_bubble_cnt); end
`endif
    reset = 1'b0;
  endtask

  task automatic test_countdown();
    logic [1:0] tin [4]  = '{2'd2, 2'd1, 2'd0, 2'd3};
    logic [1:0] texp [4] = '{2'd1, 2'd0, 2'd0, 2'd2};
    logic       fexp [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 1'b1, 32'h0000_0020 + i, 32'h3004, {32'h1, 32'h2, 32'h3 + i}, 5'd5, tin[i]);
      step();
      total++; if (bus.out_tnew !== texp[i]) begin bad++; $display("FAIL cd_tnew[%0d] got=%0d want=%0d", i, bus.out_tnew, texp[i]); end
      total++; if (bus.out_fwd_ready !== fexp[i]) begin bad++; $display("FAIL cd_fwd[%0d] got=%b want=%b", i, bus.out_fwd_ready, fexp[i]); end
      total++; if (bus.out_pc !== 32'h3004) begin bad++; $display("FAIL cd_pc[%0d] got=%h want=3004", i, bus.out_pc); end
      total++; if (bus.out_valid !== 1'b1 || bus.out_wa !== 5'd5) begin bad++; $display("FAIL cd_vwa[%0d] got=%b/%0d want=1/5", i, bus.out_valid, bus.out_wa); end
      total++; if (bus.out_data !== {32'h1, 32'h2, 32'h3 + i}) begin bad++; $display("FAIL cd_data[%0d] got=%h", i, bus.out_data); end
    end
  endtask

  task automatic test_hold();
    drive(1'b1, 1'b0, 1'b1, 32'h3C01_1234, 32'h3008, {32'h11, 32'h22, 32'h33}, 5'd7, 2'd2);
    step();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b1, 32'h1111_0000 + i, 32'h4000 + 4 * i, {3{32'hFFFF_0000 + i}}, 5'd9, 2'd3);
      step();
      total++; if (bus.out_instr !== 32'h3C01_1234) begin bad++; $display("FAIL hold_instr[%0d] got=%h want=3c011234", i, bus.out_instr); end
      total++; if (bus.out_pc !== 32'h3008) begin bad++; $display("FAIL hold_pc[%0d] got=%h want=3008", i, bus.out_pc); end
      total++; if (bus.out_tnew !== 2'd1 || bus.out_wa !== 5'd7) begin bad++; $display("FAIL hold_tw[%0d] got=%0d/%0d want=1/7", i, bus.out_tnew, bus.out_wa); end
      total++; if (bus.out_data !== {32'h11, 32'h22, 32'h33} || bus.out_valid !== 1'b1) begin bad++; $display("FAIL hold_dv[%0d] got=%h/%b", i, bus.out_data, bus.out_valid); end
    end
`ifdef PIPE_STAT_EN
    total++; if (stat_hold_cnt !== 32'd3) begin bad++; $display("FAIL hold_cnt got=%0d want=3", stat_hold_cnt); end
    total++; if (stat_bubble_cnt !== 32'd0) begin bad++; $display("FAIL hold_bub got=%0d want=0", stat_bubble_cnt); end
`endif
  endtask

  task automatic test_flush();
    logic [31:0] pc_exp;
    pc_exp = KEEP_PC ? 32'h3010 : PC_RST;
    drive(1'b0, 1'b1, 1'b1, 32'h2222_3333, 32'h3010, {3{32'h5555_AAAA}}, 5'd9, 2'd1);
    step();
    total++; if (bus.out_valid !== 1'b0 || bus.out_instr !== 32'h0) begin bad++; $display("FAIL fl_vi got=%b/%h want=0/0", bus.out_valid, bus.out_instr); end
    total++; if (bus.out_wa !== 5'd0 || bus.out_tnew !== 2'd0) begin bad++; $display("FAIL fl_wt got=%0d/%0d want=0/0", bus.out_wa, bus.out_tnew); end
    total++; if (bus.out_data !== 96'h0) begin bad++; $display("FAIL fl_data got=%h want=0", bus.out_data); end
    total++; if (bus.out_pc !== pc_exp) begin bad++; $display("FAIL fl_pc got=%h want=%h", bus.out_pc, pc_exp); end
`ifdef PIPE_STAT_EN
    total++; if (stat_bubble_cnt !== 32'd1 || stat_hold_cnt !== 32'd3) begin bad++; $display("FAIL fl_cnt got=%0d/%0d want=1/3", stat_bubble_cnt, stat_hold_cnt); end
`endif
  endtask

  task automatic test_invalid();
    drive(1'b1, 1'b0, 1'b0, 32'h0000_0001, 32'h3014, {3{32'h7}}, 5'd31, 2'd0);
    step();
    total++; if (bus.out_wa !== 5'd0) begin bad++; $display("FAIL inv_wa got=%0d want=0", bus.out_wa); end
    total++; if (bus.out_fwd_ready !== 1'b0 || bus.out_valid !== 1'b0) begin bad++; $display("FAIL inv_fv got=%b/%b want=0/0", bus.out_fwd_ready, bus.out_valid); end
    total++; if (bus.out_pc !== 32'h3014) begin bad++; $display("FAIL inv_pc got=%h want=3014", bus.out_pc); end
    drive(1'b1, 1'b0, 1'b0, 32'h0000_0002, 32'h3018, {3{32'h8}}, 5'd12, 2'd3);
    step();
    total++; if (bus.out_tnew !== 2'd0 || bus.out_wa !== 5'd0) begin bad++; $display("FAIL inv_tw got=%0d/%0d want=0/0", bus.out_tnew, bus.out_wa); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] pcs [4] = '{32'h3020, 32'h3024, 32'h3028, 32'h302C};
    logic [4:0]  was [4] = '{5'd1, 5'd0, 5'd30, 5'd4};
    logic        fexp [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 1'b1, 32'hABC0_0000 + i, pcs[i], {3{pcs[i]}}, was[i], (i == 3) ? 2'd2 : 2'd1);
      step();
      total++; if (bus.out_pc !== pcs[i] || bus.out_wa !== was[i]) begin bad++; $display("FAIL b2b_pw[%0d] got=%h/%0d want=%h/%0d", i, bus.out_pc, bus.out_wa, pcs[i], was[i]); end
      total++; if (bus.out_fwd_ready !== fexp[i]) begin bad++; $display("FAIL b2b_fwd[%0d] got=%b want=%b", i, bus.out_fwd_ready, fexp[i]); end
    end
  endtask

  task automatic test_reset_mid();
    drive(1'b0, 1'b0, 1'b1, 32'h0, 32'h3030, 96'h0, 5'd3, 2'd0);
    step();
    reset = 1'b1;
    drive(1'b1, 1'b1, 1'b1, 32'h9999_8888, 32'h3040, {3{32'h1234_5678}}, 5'd6, 2'd1);
    step();
    total++; if (bus.out_pc !== 32'h3000 || bus.out_valid !== 1'b0) begin bad++; $display("FAIL rm_pv got=%h/%b want=3000/0", bus.out_pc, bus.out_valid); end
    total++; if (bus.out_instr !== 32'h0 || bus.out_data !== 96'h0) begin bad++; $display("FAIL rm_id got=%h/%h want=0/0", bus.out_instr, bus.out_data); end
    total++; if (bus.out_wa !== 5'd0 || bus.out_tnew !== 2'd0) begin bad++; $display("FAIL rm_wt got=%0d/%0d want=0/0", bus.out_wa, bus.out_tnew); end
`ifdef PIPE_STAT_EN
    total++; if (stat_bubble_cnt !== 32'd0 || stat_hold_cnt !== 32'd0) begin bad++; $display("FAIL rm_cnt got=%0d/%0d want=0/0", stat_bubble_cnt, stat_hold_cnt); end
`endif
    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b1, 32'h0, 32'h3050, 96'h0, 5'd3, 2'd0);
    step();
    total++; if (bus.out_pc !== 32'h3000) begin bad++; $display("FAIL rm_hold_pc got=%h want=3000", bus.out_pc); end
`ifdef PIPE_STAT_EN
    total++; if (stat_hold_cnt !== 32'd1) begin bad++; $display("FAIL rm_holdcnt got=%0d want=1", stat_hold_cnt); end
`endif
  endtask

  initial begin
    test_reset();
    test_countdown();
    test_hold();
    test_flush();
    test_invalid();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
